delay_line_ctrl: RTL and testbench
==================================

Name: delay_line_ctrl

Overview:
- Multi-channel, valid-tagged delay line with runtime-selectable delay, stall and flush.
- Parametrised successor to the fixed-depth always-enabled register chain.
- Aligns datapath operands and control tags across DQN pipeline stages of unequal latency (MAC trees, activation units, Q-value compare), where stalls and batch aborts must be tolerated.

Parameters:
- DATA_WIDTH, 32, bits per channel word.
- NUM_CHANNEL, 4, parallel words delayed together under one valid bit.
- MAX_DELAY, 8, number of physical register stages; must be >= 1.
- SEL_WIDTH, 4, width of delay_sel and in_flight; must satisfy 2^SEL_WIDTH > MAX_DELAY.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous reset, active-high (asserted = 1), sampled on clk rising edge.
- en  in  1  advance enable; 0 = whole line holds.
- flush  in  1  synchronous clear of all in-flight entries.
- delay_sel  in  SEL_WIDTH  selected delay in enabled cycles, 0..MAX_DELAY.
- in_valid  in  1  input entry valid.
- in_data  in  NUM_CHANNEL*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  valid of the selected tap.
- out_data  out  NUM_CHANNEL*DATA_WIDTH  data of the selected tap; all-zero when out_valid=0.
- in_flight  out  SEL_WIDTH  count of valid entries held in all MAX_DELAY stages.
- busy  out  1  in_flight != 0.

Behaviour:
- Storage: stages S[0..MAX_DELAY-1], each holding {valid, NUM_CHANNEL words}.
- Reset (rstn=1 at an edge):
  - All stage valids, all stage data and in_flight are cleared to 0.
  - Consequently out_valid=0, out_data=0, busy=0.
  - Reset has priority over flush and en.
- Shift (en=1, flush=0):
  - S[0] <= {in_valid, in_data}; S[k] <= S[k-1] for k >= 1.
  - Data shifts unconditionally; valid qualifies it.
  - The entry leaving S[MAX_DELAY-1] is discarded.
- Hold (en=0, flush=0): all stages and in_flight retain their values. in_valid and in_data are ignored; there is no backpressure output.
- Flush (flush=1, rstn=0):
  - All stage valids and in_flight become 0 next cycle, regardless of en.
  - Input presented that cycle is dropped.
  - Stage data need not be cleared.
- Output tap, combinational from registers and delay_sel:
  - delay_sel = d with 1 <= d <= MAX_DELAY: out = S[d-1].
  - delay_sel = 0: bypass; out_valid = in_valid and out_data = in_data combinationally, independent of en.
  - delay_sel > MAX_DELAY: clamped to MAX_DELAY.
  - out_data is forced to 0 whenever out_valid = 0.
- Latency: an entry accepted at an enabled edge appears at the output after exactly d enabled edges, counting the accepting edge. Disabled cycles add latency 1:1.
- Changing delay_sel: takes effect immediately on the tap. No realignment of in-flight data. Entries may be skipped or repeated at the output; this is the caller's responsibility.
- in_flight:
  - Updated only on enabled, non-flush edges: next = in_flight + in_valid - S[MAX_DELAY-1].valid.
  - Counts all stages, independent of delay_sel.
  - Never exceeds MAX_DELAY; no wrap is possible.
  - Simultaneous enter and exit leaves it unchanged.
- No internal FSM beyond the stage registers and counter. One clock domain; no multicycle paths.

Test Plan:
- Reset: drive in_valid=1, in_data=all 0xA5A5A5A5, en=1 for 5 cycles, then rstn=1 for 1 cycle -> next cycle out_valid=0, out_data=0, in_flight=0, busy=0.
- Fixed delay: delay_sel=3, en=1; inject valid 0x11, 0x22, 0x33 (channel 0; others 0) on consecutive cycles -> out_valid=1 with 0x11/0x22/0x33 on cycles 3,4,5 after the first injection, out_valid=0 otherwise; in_flight peaks at 3 and returns to 0 eight cycles after the last injection.
- Stall: delay_sel=2; inject 0x44, then en=0 for 4 cycles, then en=1 -> out shows 0x44 exactly 2 enabled edges after injection; held stable through the stall; in_flight stays 1 during the stall.
- Flush mid-stream: delay_sel=8; inject 6 valid entries, assert flush together with en=1 and in_valid=1 (data 0x77) -> next cycle in_flight=0, busy=0; 0x77 never appears at the output.
- Bypass and clamp: delay_sel=0 with in_valid=1, in_data=0x99 -> out_valid=1, out_data=0x99 in the same cycle; delay_sel=15 with MAX_DELAY=8 -> behaves identically to delay_sel=8.
- Full occupancy: in_valid=1 continuously for 12 cycles -> in_flight saturates at 8 (enter and exit balance) and returns to 0 eight enabled cycles after in_valid drops.

Source files
------------

// File: rtl/delay_line_ctrl_if.sv
// Interface bundling the control, input and output signals of delay_line_ctrl.
//   en, flush, delay_sel : line control (driven by master)
//   in_valid, in_data    : entry presented to stage 0 (driven by master)
//   out_valid, out_data  : selected tap (driven by slave)
//   in_flight, busy      : occupancy status (driven by slave)
interface delay_line_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CHANNEL = 4,
  parameter int SEL_WIDTH   = 4
);
  logic                              en;
  logic                              flush;
  logic [SEL_WIDTH-1:0]              delay_sel;
  logic                              in_valid;
  logic [NUM_CHANNEL*DATA_WIDTH-1:0] in_data;
  logic                              out_valid;
  logic [NUM_CHANNEL*DATA_WIDTH-1:0] out_data;
  logic [SEL_WIDTH-1:0]              in_flight;
  logic                              busy;

  modport master (
    output en, flush, delay_sel, in_valid, in_data,
    input  out_valid, out_data, in_flight, busy
  );

  modport slave (
    input  en, flush, delay_sel, in_valid, in_data,
    output out_valid, out_data, in_flight, busy
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Multi-channel valid-tagged delay line with runtime-selectable tap, stall
// (en=0 holds everything) and synchronous flush of in-flight entries.
// Ports:
//   clk  : rising-edge clock
//   rstn : synchronous reset, active-high; clears valids, data and counter
//   bus  : delay_line_ctrl_if.slave (en, flush, delay_sel, in_valid, in_data,
//          out_valid, out_data, in_flight, busy)
// delay_sel=0 bypasses the line combinationally; values above MAX_DELAY are
// clamped to MAX_DELAY. out_data is zero whenever out_valid is low.
module delay_line_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CHANNEL = 4,
  parameter int MAX_DELAY   = 8,
  parameter int SEL_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  delay_line_ctrl_if.slave bus
);

  localparam int WORD_W = NUM_CHANNEL * DATA_WIDTH;
  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(MAX_DELAY);

  logic [MAX_DELAY-1:0] stage_valid;
  logic [WORD_W-1:0]    stage_data [MAX_DELAY];
  logic [SEL_WIDTH-1:0] flight;

  logic [SEL_WIDTH-1:0] sel_eff;
  logic                 tap_valid;
  logic [WORD_W-1:0]    tap_data;

  always_ff @(posedge clk) begin
    if (rstn) begin
      stage_valid <= '0;
      for (int unsigned k = 0; k < MAX_DELAY; k++) begin
        stage_data[k] <= '0;
      end
      flight <= '0;
    end else if (bus.flush) begin
      // Only valids are cleared; stale data stays masked by the valid bits.
      stage_valid <= '0;
      flight      <= '0;
    end else if (bus.en) begin
      stage_valid[0] <= bus.in_valid;
      stage_data[0]  <= bus.in_data;
      for (int unsigned k = 1; k < MAX_DELAY; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_data[k]  <= stage_data[k-1];
      end
      // Enter and exit in the same cycle cancel; the count never exceeds
      // MAX_DELAY since it mirrors the number of set stage_valid bits.
      flight <= flight + SEL_WIDTH'(bus.in_valid)
                       - SEL_WIDTH'(stage_valid[MAX_DELAY-1]);
    end
  end

  always_comb begin
    sel_eff = (bus.delay_sel > MAX_SEL) ? MAX_SEL : bus.delay_sel;
    // Default is the bypass path used for delay_sel = 0.
    tap_valid = bus.in_valid;
    tap_data  = bus.in_data;
    for (int unsigned k = 0; k < MAX_DELAY; k++) begin
      if (sel_eff == SEL_WIDTH'(k + 1)) begin
        tap_valid = stage_valid[k];
        tap_data  = stage_data[k];
      end
    end
  end

  assign bus.out_valid = tap_valid;
  assign bus.out_data  = tap_valid ? tap_data : '0;
  assign bus.in_flight = flight;
  assign bus.busy      = (flight != '0);

endmodule

// File: tb/tb_delay_line_ctrl.sv
module tb_delay_line_ctrl;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int MD = 8;
  localparam int SW = 4;
  localparam int W  = DW * NC;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_word;
    logic        exp_valid;
    logic [31:0] exp_word;
    int unsigned exp_flight;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl [12];

  delay_line_ctrl_if #(.DATA_WIDTH(DW), .NUM_CHANNEL(NC), .SEL_WIDTH(SW)) bus ();

  delay_line_ctrl #(
    .DATA_WIDTH(DW), .NUM_CHANNEL(NC), .MAX_DELAY(MD), .SEL_WIDTH(SW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] w0(input logic [31:0] x);
    return {96'b0, x};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int idx,
                           input logic ev, input logic [W-1:0] ed);
    check({name, ".out_valid"}, idx, W'(bus.out_valid), W'(ev));
    check({name, ".out_data"},  idx, bus.out_data, ed);
  endtask

  task automatic check_flight(input string name, input int idx, input int unsigned ef);
    check({name, ".in_flight"}, idx, W'(bus.in_flight), W'(ef));
    check({name, ".busy"},      idx, W'(bus.busy), W'(ef != 0));
  endtask

  task automatic drive(input logic en, input logic fl, input logic v,
                       input logic [W-1:0] d, input logic [SW-1:0] sel);
    bus.en        = en;
    bus.flush     = fl;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.delay_sel = sel;
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Fixed delay 3: 0x11, 0x22, 0x33 injected on cycles 0..2.
    tbl[0]  = '{1'b1, 32'h11, 1'b0, 32'h00, 0};
    tbl[1]  = '{1'b1, 32'h22, 1'b0, 32'h00, 1};
    tbl[2]  = '{1'b1, 32'h33, 1'b0, 32'h00, 2};
    tbl[3]  = '{1'b0, 32'h00, 1'b1, 32'h11, 3};
    tbl[4]  = '{1'b0, 32'h00, 1'b1, 32'h22, 3};
    tbl[5]  = '{1'b0, 32'h00, 1'b1, 32'h33, 3};
    tbl[6]  = '{1'b0, 32'h00, 1'b0, 32'h00, 3};
    tbl[7]  = '{1'b0, 32'h00, 1'b0, 32'h00, 3};
    tbl[8]  = '{1'b0, 32'h00, 1'b0, 32'h00, 3};
    tbl[9]  = '{1'b0, 32'h00, 1'b0, 32'h00, 2};
    tbl[10] = '{1'b0, 32'h00, 1'b0, 32'h00, 1};
    tbl[11] = '{1'b0, 32'h00, 1'b0, 32'h00, 0};

    rstn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 4'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;

    // Reset: fill with A5 pattern, then reset while en=1/in_valid=1.
    drive(1'b1, 1'b0, 1'b1, {4{32'hA5A5A5A5}}, 4'd1);
    for (int i = 0; i < 5; i++) tick();
    #1;
    check_flight("pre_reset", 0, 5);
    check_out("pre_reset", 0, 1'b1, {4{32'hA5A5A5A5}});
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, 4'd1);
    #1;
    check_out("reset", 0, 1'b0, '0);
    check_flight("reset", 0, 0);
    drive(1'b1, 1'b0, 1'b0, '0, 4'd8);
    #1;
    check_out("reset_s8", 0, 1'b0, '0);
    tick();

    // Table-driven fixed-delay sequence.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, tbl[i].in_valid, w0(tbl[i].in_word), 4'd3);
      #1;
      check_out("fixed", i, tbl[i].exp_valid, w0(tbl[i].exp_word));
      check_flight("fixed", i, tbl[i].exp_flight);
      tick();
    end

    // Stall: delay 2, one entry, then 4 disabled cycles with junk input.
    drive(1'b1, 1'b0, 1'b1, w0(32'h44), 4'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, w0(32'hEE), 4'd2);
      #1;
      check_out("stall", i, 1'b0, '0);
      check_flight("stall", i, 1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, '0, 4'd2);
    #1;
    check_out("stall_resume", 0, 1'b0, '0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0, 4'd2);
      #1;
      check_out("stall_out", i, 1'b1, w0(32'h44));
      check_flight("stall_out", i, 1);
      tick();
    end
    // Flush with en=0 must still clear.
    drive(1'b0, 1'b1, 1'b0, '0, 4'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 4'd2);
    #1;
    check_flight("flush_noen", 0, 0);
    check_out("flush_noen", 0, 1'b0, '0);

    // Flush mid-stream: 6 entries, then flush with a valid 0x77 offered.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, w0(32'h60 + 32'(i)), 4'd8);
      tick();
    end
    #1;
    check_flight("pre_flush", 0, 6);
    drive(1'b1, 1'b1, 1'b1, w0(32'h77), 4'd8);
    tick();
    // Follow where 0x77 would be if it had been accepted.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 4'(i + 1));
      #1;
      check_out("flush", i, 1'b0, '0);
      if (i == 0) check_flight("flush", i, 0);
      tick();
    end

    // Bypass, independent of en; out_data masked when invalid.
    drive(1'b0, 1'b0, 1'b1, w0(32'h99), 4'd0);
    #1;
    check_out("bypass", 0, 1'b1, w0(32'h99));
    drive(1'b0, 1'b0, 1'b0, w0(32'h99), 4'd0);
    #1;
    check_out("bypass", 1, 1'b0, '0);

    // Clamp: one entry walked to the last stage.
    drive(1'b1, 1'b0, 1'b1, w0(32'hAB), 4'd0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 4'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 4'd8);
    #1;
    check_out("clamp_s8", 0, 1'b1, w0(32'hAB));
    drive(1'b0, 1'b0, 1'b0, '0, 4'd15);
    #1;
    check_out("clamp_s15", 0, 1'b1, w0(32'hAB));
    drive(1'b0, 1'b0, 1'b0, '0, 4'd7);
    #1;
    check_out("clamp_s7", 0, 1'b0, '0);
    check_flight("clamp", 0, 1);
    drive(1'b1, 1'b0, 1'b0, '0, 4'd15);
    tick();
    #1;
    check_flight("clamp_exit", 0, 0);
    check_out("clamp_exit", 0, 1'b0, '0);

    // Full occupancy: 12 consecutive valids, then drain.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b1, w0(32'(i + 1)), 4'd8);
      #1;
      check_flight("full", i, (i < 8) ? i : 8);
      if (i >= 8) check_out("full", i, 1'b1, w0(32'(i - 7)));
      else        check_out("full", i, 1'b0, '0);
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 4'd8);
      #1;
      check_flight("drain", k, 8 - k);
      if (k <= 7) check_out("drain", k, 1'b1, w0(32'(k + 5)));
      else        check_out("drain", k, 1'b0, '0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
